// File: rtl/tdc_hit_sequencer.sv
// tdc_hit_sequencer
//   Controller for a CARRY4 delay-chain TDC. Synchronises the chain taps,
//   detects a 0 -> nonzero transition as a hit, encodes the thermometer code
//   into a fine count, pairs it with a free-running coarse counter and offers
//   the timestamp downstream over valid/ready. After each transfer the chain
//   must read all-zero for DEAD_CYCLES consecutive samples before re-arming.
//
//   Optional build macro: TDC_BUBBLE_FILTER_EN
//     defined   : fine code = population count of the sampled taps
//     undefined : fine code = run of ones from bit 0 up to the first zero
//
// Ports
//   clk        : sole clock, taps sampled on its rising edge
//   rst        : asynchronous reset, active low
//   taps       : raw chain outputs (asynchronous to clk)
//   arm        : level, 1 = accept hits
//   out_ready  : downstream accepts the timestamp
//   ts_valid   : timestamp available
//   ts_coarse  : coarse count at the sampling edge
//   ts_fine    : encoded thermometer count, 0..NUM
//   ts_sat     : every tap was 1 (hit older than the chain)
//   missed_cnt : hits dropped while not armed-and-empty, saturates at 255
//   busy       : state is not IDLE
module tdc_hit_sequencer #(
  parameter int unsigned NUM         = 12,
  parameter int unsigned COARSE_W    = 16,
  parameter int unsigned DEAD_CYCLES = 2,
  localparam int unsigned FW         = $clog2(NUM + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM-1:0]      taps,
  input  logic                arm,
  input  logic                out_ready,
  output logic                ts_valid,
  output logic [COARSE_W-1:0] ts_coarse,
  output logic [FW-1:0]       ts_fine,
  output logic                ts_sat,
  output logic [7:0]          missed_cnt,
  output logic                busy
);

  // Counter only needs to reach DEAD_CYCLES-1; the final zero sample exits DEAD.
  localparam int unsigned DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, HOLD, DEAD} state_t;

  state_t              state, state_d;
  logic [NUM-1:0]      s1, s2, s2_prev;
  logic [COARSE_W-1:0] coarse, c1, c2;
  logic [DW-1:0]       dead_cnt, dead_d;
  logic                hit, capture, miss;

  function automatic logic [FW-1:0] enc(input logic [NUM-1:0] v);
    logic [FW-1:0] cnt;
    cnt = '0;
`ifdef TDC_BUBBLE_FILTER_EN
    for (int unsigned i = 0; i < NUM; i++) cnt = cnt + FW'(v[i]);
`else
    begin
      logic run;
      run = 1'b1;
      for (int unsigned i = 0; i < NUM; i++) begin
        run = run & v[i];
        cnt = cnt + FW'(run);
      end
    end
`endif
    return cnt;
  endfunction

  assign hit      = (s2 != '0) && (s2_prev == '0);
  assign ts_valid = (state == HOLD);
  assign busy     = (state != IDLE);

  // Two-stage synchroniser with the coarse count travelling alongside.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1      <= '0;
      s2      <= '0;
      s2_prev <= '0;
      c1      <= '0;
      c2      <= '0;
      coarse  <= '0;
    end else begin
      s1      <= taps;
      s2      <= s1;
      s2_prev <= s2;
      c1      <= coarse;
      c2      <= c1;
      coarse  <= coarse + COARSE_W'(1);
    end
  end

  always_comb begin
    state_d = state;
    dead_d  = dead_cnt;
    capture = 1'b0;
    miss    = 1'b0;
    case (state)
      IDLE: begin
        miss = hit;
        if (arm) state_d = ARMED;
      end
      ARMED: begin
        // A hit wins over a simultaneous disarm.
        if (hit) begin
          state_d = HOLD;
          capture = 1'b1;
        end else if (!arm) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        miss = hit;
        if (out_ready) begin
          state_d = DEAD;
          dead_d  = '0;
        end
      end
      DEAD: begin
        miss = hit;
        if (s2 == '0) begin
          if (dead_cnt == DW'(DEAD_CYCLES - 1)) begin
            state_d = arm ? ARMED : IDLE;
            dead_d  = '0;
          end else begin
            dead_d = dead_cnt + DW'(1);
          end
        end else begin
          dead_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      dead_cnt   <= '0;
      ts_coarse  <= '0;
      ts_fine    <= '0;
      ts_sat     <= 1'b0;
      missed_cnt <= '0;
    end else begin
      state    <= state_d;
      dead_cnt <= dead_d;
      if (capture) begin
        ts_coarse <= c2;
        ts_fine   <= enc(s2);
        ts_sat    <= &s2;
      end
      if (miss && (missed_cnt != 8'hFF)) missed_cnt <= missed_cnt + 8'd1;
    end
  end

endmodule
